// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, forward-select encodings and hazard-tracker types.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic [4:0] dest;
  } trk_entry_t;

  // $0 is hardwired, so a write to it is never a real producer.
  function automatic logic fwd_match(input trk_entry_t e, input logic [4:0] r);
    return e.valid && e.regwrite && (e.dest == r) && (r != 5'd0);
  endfunction

endpackage

// File: rtl/md_busy_ctrl.sv
// Mult/div occupancy sequencer: busy for exactly MD_LATENCY cycles after a start edge.
module md_busy_ctrl
  import mips_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic start,
  output logic busy
);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state <= MD_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state <= MD_BUSY;
            cnt   <= CNT_W'(MD_LATENCY);
            busy  <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (cnt == CNT_W'(1)) begin
            state <= MD_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt   <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= MD_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// ID-stage hazard detector and EX-aligned forward-select generator with shadow EX/MEM tracking.
module hazard_forward_ctrl
  import mips_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] Instruction_IN,
  input  logic        ID_Valid,
  input  logic        ID_RegWrite,
  input  logic        ID_MemRead,
  input  logic [4:0]  ID_WriteReg,
  input  logic        Flush,
  output logic        Stall,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic        MD_Busy
);

  logic [5:0] op, funct;
  logic [4:0] rs, rt;
  logic       uses_rs, uses_rt, is_md, reads_hilo;
  logic       load_use, md_haz, issue;
  logic [1:0] fwd_a, fwd_b;
  logic       unused_bits;
  trk_entry_t ex_e, mem_e;

  assign op          = Instruction_IN[31:26];
  assign rs          = Instruction_IN[25:21];
  assign rt          = Instruction_IN[20:16];
  assign funct       = Instruction_IN[5:0];
  assign unused_bits = ^Instruction_IN[15:6];

  assign uses_rs    = !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI) ||
                        ((op == OP_RTYPE) && ((funct == FN_SLL) || (funct == FN_SRL) ||
                                              (funct == FN_SRA))));
  assign uses_rt    = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  assign is_md      = (op == OP_RTYPE) && ((funct == FN_MULT) || (funct == FN_MULTU) ||
                                           (funct == FN_DIV)  || (funct == FN_DIVU));
  assign reads_hilo = (op == OP_RTYPE) && ((funct == FN_MFHI) || (funct == FN_MFLO));

  assign load_use = ex_e.memread && ((uses_rs && fwd_match(ex_e, rs)) ||
                                     (uses_rt && fwd_match(ex_e, rt)));
  assign md_haz   = MD_Busy && (is_md || reads_hilo);
  assign Stall    = ID_Valid && !Flush && (load_use || md_haz);
  assign issue    = ID_Valid && !Stall && !Flush;

  // A load in EX never forwards from EX/MEM; that case has already stalled.
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (uses_rs && fwd_match(ex_e, rs) && !ex_e.memread) fwd_a = FWD_EXMEM;
    else if (uses_rs && fwd_match(mem_e, rs))             fwd_a = FWD_MEMWB;
    if (uses_rt && fwd_match(ex_e, rt) && !ex_e.memread) fwd_b = FWD_EXMEM;
    else if (uses_rt && fwd_match(mem_e, rt))             fwd_b = FWD_MEMWB;
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      ex_e     <= '0;
      mem_e    <= '0;
      ForwardA <= FWD_REG;
      ForwardB <= FWD_REG;
    end else begin
      mem_e <= ex_e;
      if (issue) begin
        ex_e     <= '{valid: 1'b1, regwrite: ID_RegWrite, memread: ID_MemRead, dest: ID_WriteReg};
        ForwardA <= fwd_a;
        ForwardB <= fwd_b;
      end else begin
        ex_e     <= '0;
        ForwardA <= FWD_REG;
        ForwardB <= FWD_REG;
      end
    end
  end

  md_busy_ctrl #(
    .MD_LATENCY (MD_LATENCY),
    .CNT_W      (CNT_W)
  ) u_md (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .start (issue && is_md),
    .busy  (MD_Busy)
  );

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed scoreboard bench for hazard_forward_ctrl (MD_LATENCY = 4).
module tb_hazard_forward_ctrl;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [31:0] Instruction_IN;
  logic        ID_Valid, ID_RegWrite, ID_MemRead, Flush;
  logic [4:0]  ID_WriteReg;
  logic        Stall, MD_Busy;
  logic [1:0]  ForwardA, ForwardB;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       busy;
    string      tag;
  } exp_t;
  exp_t exp_q[$];

  always #5 CLOCK = ~CLOCK;

  hazard_forward_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
    .CLOCK          (CLOCK),
    .RESET          (RESET),
    .Instruction_IN (Instruction_IN),
    .ID_Valid       (ID_Valid),
    .ID_RegWrite    (ID_RegWrite),
    .ID_MemRead     (ID_MemRead),
    .ID_WriteReg    (ID_WriteReg),
    .Flush          (Flush),
    .Stall          (Stall),
    .ForwardA       (ForwardA),
    .ForwardB       (ForwardB),
    .MD_Busy        (MD_Busy)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at posedge+1: drive ID, check Stall, push expected EX-stage outputs, advance one edge.
  task automatic step(input string tag, input logic [31:0] ins, input logic v, rw, mr,
                      input logic [4:0] wr, input logic fl, rst,
                      input logic es, input logic [1:0] efa, efb, input logic ebusy);
    exp_t e;
    Instruction_IN = ins;
    ID_Valid       = v;
    ID_RegWrite    = rw;
    ID_MemRead     = mr;
    ID_WriteReg    = wr;
    Flush          = fl;
    RESET          = rst;
    #1;
    check({tag, ".stall"}, {31'd0, Stall}, {31'd0, es});
    e.fa = efa; e.fb = efb; e.busy = ebusy; e.tag = tag;
    exp_q.push_back(e);
    @(posedge CLOCK);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=%0d expected=1", tag, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      check({e.tag, ".fwdA"}, {30'd0, ForwardA}, {30'd0, e.fa});
      check({e.tag, ".fwdB"}, {30'd0, ForwardB}, {30'd0, e.fb});
      check({e.tag, ".busy"}, {31'd0, MD_Busy}, {31'd0, e.busy});
    end
  endtask

  task automatic bubble(input string tag, input logic ebusy);
    step(tag, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, ebusy);
  endtask

  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_MULT = 6'h18, F_MFLO = 6'h12;
  localparam logic [5:0] O_LW = 6'h23;

  initial begin
    RESET = 1'b0; Instruction_IN = '0; ID_Valid = 1'b0; ID_RegWrite = 1'b0;
    ID_MemRead = 1'b0; ID_WriteReg = '0; Flush = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    check("rst.fwdA", {30'd0, ForwardA}, 32'd0);
    check("rst.fwdB", {30'd0, ForwardB}, 32'd0);
    check("rst.busy", {31'd0, MD_Busy}, 32'd0);
    check("rst.stall", {31'd0, Stall}, 32'd0);

    // 1: back-to-back dependent ALU ops forward from EX/MEM
    step("t1.add3", rtype(1, 2, 3, F_ADD), 1, 1, 0, 3, 0, 1, 0, 2'b00, 2'b00, 0);
    step("t1.add4", rtype(3, 5, 4, F_ADD), 1, 1, 0, 4, 0, 1, 0, 2'b10, 2'b00, 0);
    bubble("t1.b0", 0); bubble("t1.b1", 0);

    // 2: distance-two producer forwards from MEM/WB; rs=$0 never forwards
    step("t2.add3", rtype(1, 2, 3, F_ADD), 1, 1, 0, 3, 0, 1, 0, 2'b00, 2'b00, 0);
    bubble("t2.nop", 0);
    step("t2.sub", rtype(0, 3, 4, F_SUB), 1, 1, 0, 4, 0, 1, 0, 2'b00, 2'b01, 0);
    bubble("t2.b0", 0); bubble("t2.b1", 0);

    // 3: load-use inserts one bubble, then both operands come from MEM/WB
    step("t3.lw", itype(O_LW, 1, 3, 16'h0), 1, 1, 1, 3, 0, 1, 0, 2'b00, 2'b00, 0);
    step("t3.add_stall", rtype(3, 3, 4, F_ADD), 1, 1, 0, 4, 0, 1, 1, 2'b00, 2'b00, 0);
    step("t3.add_issue", rtype(3, 3, 4, F_ADD), 1, 1, 0, 4, 0, 1, 0, 2'b01, 2'b01, 0);
    bubble("t3.b0", 0); bubble("t3.b1", 0);

    // 4: writes to $0 never create dependencies
    step("t4.add0", rtype(1, 2, 0, F_ADD), 1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    step("t4.add5", rtype(0, 0, 5, F_ADD), 1, 1, 0, 5, 0, 1, 0, 2'b00, 2'b00, 0);
    step("t4.lw0", itype(O_LW, 1, 0, 16'h4), 1, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    step("t4.use0", rtype(0, 0, 6, F_ADD), 1, 1, 0, 6, 0, 1, 0, 2'b00, 2'b00, 0);
    bubble("t4.b0", 0); bubble("t4.b1", 0);

    // 5: mult busy window of 4 cycles; mflo stalls; flush mid-window leaves count alone
    step("t5.mult", rtype(1, 2, 0, F_MULT), 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1);
    step("t5.mflo_s1", rtype(0, 0, 3, F_MFLO), 1, 1, 0, 3, 0, 1, 1, 2'b00, 2'b00, 1);
    step("t5.mflo_fl", rtype(0, 0, 3, F_MFLO), 1, 1, 0, 3, 1, 1, 0, 2'b00, 2'b00, 1);
    step("t5.mflo_s3", rtype(0, 0, 3, F_MFLO), 1, 1, 0, 3, 0, 1, 1, 2'b00, 2'b00, 1);
    step("t5.mflo_s4", rtype(0, 0, 3, F_MFLO), 1, 1, 0, 3, 0, 1, 1, 2'b00, 2'b00, 0);
    step("t5.mflo_go", rtype(0, 0, 3, F_MFLO), 1, 1, 0, 3, 0, 1, 0, 2'b00, 2'b00, 0);
    bubble("t5.b0", 0); bubble("t5.b1", 0);

    // 6a: flush beats a load-use stall and the squashed slot becomes a bubble
    step("t6.lw", itype(O_LW, 1, 3, 16'h0), 1, 1, 1, 3, 0, 1, 0, 2'b00, 2'b00, 0);
    step("t6.add_fl", rtype(3, 3, 4, F_ADD), 1, 1, 0, 4, 1, 1, 0, 2'b00, 2'b00, 0);
    step("t6.add_next", rtype(3, 3, 4, F_ADD), 1, 1, 0, 4, 0, 1, 0, 2'b01, 2'b01, 0);
    bubble("t6.b0", 0); bubble("t6.b1", 0);

    // 6b: reset mid-busy clears busy and forwards that would otherwise be 10
    step("t6.mult", rtype(1, 2, 0, F_MULT), 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1);
    step("t6.add3", rtype(1, 2, 3, F_ADD), 1, 1, 0, 3, 0, 1, 0, 2'b00, 2'b00, 1);
    step("t6.rst", rtype(3, 5, 4, F_ADD), 1, 1, 0, 4, 0, 0, 0, 2'b00, 2'b00, 0);
    step("t6.after", rtype(3, 5, 4, F_ADD), 1, 1, 0, 4, 0, 1, 0, 2'b00, 2'b00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage MIPS pipeline.
- Sits beside the ID stage and observes the instruction being decoded.
- Keeps its own shadow record of the writers now in EX and MEM, so it needs no taps into the other pipeline stages.
- Produces combinational Stall plus registered ALU-operand forward selects aligned to the EX stage, and sequences the multi-cycle HI/LO (mult/div) busy window.

Parameters:
- MD_LATENCY, 4: cycles the mult/div unit is busy after a mult/div issues; legal range 1..15.
- CNT_W, 4: width of the busy counter; must satisfy 2^CNT_W > MD_LATENCY.

Ports:
- CLOCK  input  1  pipeline clock, all state on rising edge
- RESET  input  1  synchronous, active-low reset
- Instruction_IN  input  32  ID-stage instruction
- ID_Valid  input  1  ID instruction is real (not a bubble)
- ID_RegWrite  input  1  ID instruction writes the GPR file
- ID_MemRead  input  1  ID instruction is a load
- ID_WriteReg  input  5  destination GPR of the ID instruction
- Flush  input  1  squash the ID instruction (taken branch/jump)
- Stall  output  1  hold PC and IF/ID; insert bubble into ID/EX
- ForwardA  output  2  EX operand-A (rs) source select
- ForwardB  output  2  EX operand-B (rt) source select
- MD_Busy  output  1  mult/div unit is occupied

Behaviour:
- Decode from Instruction_IN:
  - rs = [25:21], rt = [20:16], op = [31:26], funct = [5:0].
  - uses_rs: every instruction except J (0x02), JAL (0x03), LUI (0x0F), and R-type SLL/SRL/SRA (funct 0x00/0x02/0x03).
  - uses_rt: R-type, BEQ (0x04), BNE (0x05), SW (0x2B).
  - is_md: op 0 with funct 0x18..0x1B.
  - reads_hilo: op 0 with funct 0x10 or 0x12.
- Shadow tracker: two entries, EXe and MEMe, each holding {valid, regwrite, memread, dest}.
  - Every cycle: MEMe <= EXe.
  - EXe <= ID fields if issue, else an all-zero bubble.
  - issue = ID_Valid & !Stall & !Flush.
- Match condition for source register r against an entry: valid & regwrite & dest==r & r!=0. Register $0 never matches.
- Load-use hazard: EXe.memread & (uses_rs & match(rs, EXe) | uses_rt & match(rt, EXe)).
- MD hazard: MD_Busy & (is_md | reads_hilo).
- Stall (combinational, same cycle) = ID_Valid & !Flush & (load-use | MD hazard). Flush has priority over Stall.
- Forward select, computed in ID and registered into ForwardA/ForwardB at the edge, valid while the instruction is in EX:
  - 10 = EX/MEM result: operand used, matches EXe, and EXe is not a load. EXe has priority over MEMe.
  - 01 = MEM/WB result: operand used and matches MEMe (loads allowed).
  - 00 = register file value: every other case.
  - If not issuing (stall, flush, invalid), register 00.
- WB-stage writes are not tracked; the register file is write-before-read.
- Latency: Stall 0 cycles; Forward 1 cycle.
- MD sequencer: states MD_IDLE and MD_BUSY, with a down-counter cnt.
  - MD_IDLE: issue & is_md -> MD_BUSY with cnt = MD_LATENCY.
  - MD_BUSY: cnt decrements each cycle; on cnt==1 -> MD_IDLE with cnt = 0.
  - MD_Busy = (state==MD_BUSY); it is high for exactly MD_LATENCY cycles after the issue edge.
  - A mult/div cannot issue while busy, because it stalls.
- Reset (RESET low at an edge):
  - Tracker entries invalid.
  - ForwardA = ForwardB = 00.
  - MD_IDLE, cnt = 0, MD_Busy = 0.
  - Stall therefore evaluates to 0 until new hazards appear.
  - Reset asserted mid-busy aborts the busy window immediately.
- Simultaneous events:
  - A load-use stall and an MD hazard in the same cycle give a single Stall; it releases only when both clear.
  - Flush during MD_BUSY does not alter the counter.

Decomposition:
- Shared package mips_pkg holds:
  - Opcode and funct constants (J, JAL, LUI, BEQ, BNE, SW, MULT..DIVU, MFHI, MFLO, SLL/SRL/SRA).
  - FWD_REG, FWD_MEMWB, FWD_EXMEM encodings.
  - MD state enum.
- One sub-module, md_busy_ctrl, implements the MD state machine and counter: inputs start/CLOCK/RESET, output busy.

Test Plan:
1. add $3,$1,$2 then add $4,$3,$5 back-to-back -> Stall=0; ForwardA=10, ForwardB=00 during the second add's EX cycle.
2. add $3,$1,$2; nop; sub $4,$0,$3 -> ForwardB=01 and ForwardA=00 (rs=$0) in sub's EX cycle.
3. lw $3,0($1) then add $4,$3,$3 -> Stall=1 for exactly one cycle with ForwardA/B=00 (bubble); next cycle add issues, and in its EX cycle ForwardA=ForwardB=01.
4. add $0,$1,$2 then add $5,$0,$0, and lw $0 then use of $0 -> no Stall, all Forward=00.
5. MD_LATENCY=4: mult $1,$2 then mflo $3 -> MD_Busy high 4 cycles; Stall high while MD_Busy; mflo issues on the first cycle MD_Busy=0.
6. Flush=1 concurrent with a load-use condition -> Stall=0 and next Forward=00. Separately, RESET low during MD_BUSY -> next edge MD_Busy=0, ForwardA/B=00.
